// File: rtl/psum_wr_packer_if.sv
// psum_wr_packer_if: per-kernel psum streams in, BRAM write port out
interface psum_wr_packer_if #(
  parameter int BIT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [BIT_WIDTH-1:0]  i_psum_kn0, i_psum_kn1, i_psum_kn2, i_psum_kn3;
  logic                  i_psum_kn0_val, i_psum_kn1_val, i_psum_kn2_val, i_psum_kn3_val;
  logic                  i_stall;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic                  o_wren;
  logic [DATA_WIDTH-1:0] o_wdat;
  modport master (
    input  i_psum_kn0, i_psum_kn1, i_psum_kn2, i_psum_kn3,
    input  i_psum_kn0_val, i_psum_kn1_val, i_psum_kn2_val, i_psum_kn3_val,
    input  i_stall,
    output o_addr, o_wren, o_wdat
  );
  modport slave (
    output i_psum_kn0, i_psum_kn1, i_psum_kn2, i_psum_kn3,
    output i_psum_kn0_val, i_psum_kn1_val, i_psum_kn2_val, i_psum_kn3_val,
    output i_stall,
    input  o_addr, o_wren, o_wdat
  );
endinterface

// File: rtl/psum_wr_packer.sv
// psum_wr_packer: packs four kernels' 8-bit psums into 32-bit words and writes them to BRAM
module psum_wr_packer #(
  parameter int BIT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [REG_WIDTH-1:0]  i_conf_cnt,
  input  logic [ADDR_WIDTH-1:0] i_conf_base,
  input  logic [ADDR_WIDTH-1:0] i_conf_kn_stride,
  psum_wr_packer_if.master      bus,
  output logic                  o_done,
  output logic                  o_overflow
);
  localparam int NB  = DATA_WIDTH / BIT_WIDTH;
  localparam int NBW = $clog2(NB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0]            state, ptr, gnt;
  logic                  gnt_v;
  logic [REG_WIDTH-1:0]  cnt_q;
  logic [ADDR_WIDTH-1:0] base_q, stride_q;
  logic [BIT_WIDTH-1:0]  psum [4];
  logic [3:0]            val, ne, cnt_eq, pk_empty, pop, ovf;
  logic [ADDR_WIDTH-1:0] head_addr [4];
  logic [DATA_WIDTH-1:0] head_dat [4];
  assign psum = '{bus.i_psum_kn0, bus.i_psum_kn1, bus.i_psum_kn2, bus.i_psum_kn3};
  assign val = {bus.i_psum_kn3_val, bus.i_psum_kn2_val, bus.i_psum_kn1_val, bus.i_psum_kn0_val};
  assign pop = {3'b0, gnt_v} << gnt;
  assign o_done = state == DONE;
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [REG_WIDTH-1:0]  cnt_v;
    logic [DATA_WIDTH-1:0] pk_d, word;
    logic [NBW-1:0]        pk_n;
    logic [ADDR_WIDTH-1:0] widx, waddr;
    logic [AW-1:0]         wp, rp;
    logic [LW-1:0]         lvl;
    logic                  acc, last, push;
    logic [ADDR_WIDTH-1:0] m_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] m_dat [FIFO_DEPTH];
    assign acc = state == RUN && val[k] && cnt_v < cnt_q;
    assign last = acc && (pk_n == NBW'(NB - 1) || cnt_v + REG_WIDTH'(1) == cnt_q);
    assign word = pk_d | (DATA_WIDTH'(psum[k]) << (BIT_WIDTH * pk_n));
    assign waddr = base_q + ADDR_WIDTH'(k) * stride_q + (widx << 2);
    assign push = last && (lvl != LW'(FIFO_DEPTH) || pop[k]);
    assign ovf[k] = last && lvl == LW'(FIFO_DEPTH) && !pop[k];
    assign ne[k] = lvl != '0;
    assign cnt_eq[k] = cnt_v == cnt_q;
    assign pk_empty[k] = pk_n == '0;
    assign head_addr[k] = m_addr[rp];
    assign head_dat[k] = m_dat[rp];
    // lane packer, word index and FIFO pointers; a completed or final partial word leaves the packer on the push edge
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_v <= '0;
        pk_d  <= '0;
        pk_n  <= '0;
        widx  <= '0;
        wp    <= '0;
        rp    <= '0;
        lvl   <= '0;
      end else begin
        cnt_v <= i_start ? '0 : cnt_v + REG_WIDTH'(acc);
        pk_d  <= (i_start || last) ? '0 : acc ? word : pk_d;
        pk_n  <= (i_start || last) ? '0 : pk_n + NBW'(acc);
        widx  <= i_start ? '0 : widx + ADDR_WIDTH'(last);
        wp    <= i_start ? '0 : wp + AW'(push);
        rp    <= i_start ? '0 : rp + AW'(pop[k]);
        lvl   <= i_start ? '0 : lvl + LW'(push) - LW'(pop[k]);
      end
    end
    // FIFO storage holds address and data together so the arbiter needs no lane arithmetic
    always_ff @(posedge clk) begin
      if (push) begin
        m_addr[wp] <= waddr;
        m_dat[wp]  <= word;
      end
    end
  end
  // round-robin grant: the lowest offset from ptr among non-empty FIFOs wins
  always_comb begin
    gnt_v = 1'b0;
    gnt   = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (!bus.i_stall && ne[ptr + 2'(i)]) begin
        gnt_v = 1'b1;
        gnt   = ptr + 2'(i);
      end
    end
  end
  // control FSM, config latch, registered write port and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      stride_q   <= '0;
      bus.o_addr <= '0;
      bus.o_wdat <= '0;
      bus.o_wren <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state      <= i_start ? RUN :
                    (state == RUN && &cnt_eq) ? DRAIN :
                    (state == DRAIN && &pk_empty && ~|ne) ? DONE : state;
      cnt_q      <= i_start ? i_conf_cnt : cnt_q;
      base_q     <= i_start ? i_conf_base : base_q;
      stride_q   <= i_start ? i_conf_kn_stride : stride_q;
      ptr        <= i_start ? '0 : gnt_v ? gnt + 2'd1 : ptr;
      bus.o_wren <= gnt_v && !i_start;
      bus.o_addr <= gnt_v ? head_addr[gnt] : bus.o_addr;
      bus.o_wdat <= gnt_v ? head_dat[gnt] : bus.o_wdat;
      o_overflow <= !i_start && (o_overflow || |ovf);
    end
  end
endmodule

// File: tb/tb_psum_wr_packer.sv
// tb_psum_wr_packer: table-driven runs with a write scoreboard plus stall, overflow and reset sequences
module tb_psum_wr_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_start = 1'b0;
  logic [31:0] conf_cnt = '0, conf_base = '0, conf_stride = '0;
  logic        o_done, o_overflow;
  psum_wr_packer_if bus ();
  psum_wr_packer dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (i_start),
    .i_conf_cnt       (conf_cnt),
    .i_conf_base      (conf_base),
    .i_conf_kn_stride (conf_stride),
    .bus              (bus),
    .o_done           (o_done),
    .o_overflow       (o_overflow)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] dat;
  } wr_t;
  typedef struct {
    logic [31:0] cnt;
    logic [31:0] base;
    logic [31:0] stride;
    int          len;
    int          nwr;
  } vec_t;
  wr_t         sb[$];
  wr_t         mon_e;
  logic [31:0] wr_mem [logic [31:0]];
  int          tests = 0, fails = 0, wr_cnt = 0;
  logic        expect_wr = 1'b0, done_q = 1'b0, prev_wren = 1'b0;
  vec_t        vecs [6];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      done_q    = 1'b0;
      prev_wren = 1'b0;
    end else begin
      if (bus.o_wren) begin
        wr_cnt++;
        wr_mem[bus.o_addr] = bus.o_wdat;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %h data %h", bus.o_addr, bus.o_wdat);
        end else begin
          mon_e = sb.pop_front();
          chk("wr_addr", bus.o_addr, mon_e.addr);
          chk("wr_data", bus.o_wdat, mon_e.dat);
        end
      end
      if (o_done && !done_q && expect_wr) chk("done_after_last_write", 32'(prev_wren), 32'd1);
      done_q    = o_done;
      prev_wren = bus.o_wren;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic [3:0] m, int i);
    bus.i_psum_kn0 = 8'(i);
    bus.i_psum_kn1 = 8'(16 + i);
    bus.i_psum_kn2 = 8'(32 + i);
    bus.i_psum_kn3 = 8'(48 + i);
    bus.i_psum_kn0_val = m[0];
    bus.i_psum_kn1_val = m[1];
    bus.i_psum_kn2_val = m[2];
    bus.i_psum_kn3_val = m[3];
  endtask
  task automatic start(logic [31:0] c, logic [31:0] b, logic [31:0] s);
    conf_cnt = c;
    conf_base = b;
    conf_stride = s;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask
  task automatic model(logic [31:0] c, logic [31:0] b, logic [31:0] s);
    for (int j = 0; 32'(4 * j) < c; j++) begin
      for (int k = 0; k < 4; k++) begin
        wr_t w;
        w.addr = b + 32'(k) * s + 32'(4 * j);
        w.dat = '0;
        for (int q = 0; q < 4; q++)
          if (32'(4 * j + q) < c) w.dat |= 32'((k * 16 + 4 * j + q) & 255) << (8 * q);
        sb.push_back(w);
      end
    end
  endtask
  task automatic run_vec(vec_t v);
    int n;
    wr_cnt = 0;
    wr_mem.delete();
    expect_wr = v.nwr > 0;
    model(v.cnt, v.base, v.stride);
    start(v.cnt, v.base, v.stride);
    for (int i = 0; i < v.len; i++) begin
      drive(4'hF, i);
      step();
    end
    drive(4'h0, 0);
    n = 0;
    while (!o_done && n < 200) begin
      step();
      n++;
    end
    chk("done_seen", 32'(o_done), 32'd1);
    step();
    step();
    chk("write_count", 32'(wr_cnt), 32'(v.nwr));
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("no_overflow", 32'(o_overflow), 32'd0);
  endtask
  initial begin
    int n;
    vecs[0] = '{32'd8, 32'h1000, 32'h100, 8, 8};
    vecs[1] = '{32'd6, 32'h1000, 32'h100, 6, 8};
    vecs[2] = '{32'd4, 32'h1000, 32'h100, 10, 4};
    vecs[3] = '{32'd0, 32'h1000, 32'h100, 3, 0};
    vecs[4] = '{32'd5, 32'hFFFF_FFF8, 32'h4, 5, 8};
    vecs[5] = '{32'd1, 32'h3000, 32'h40, 1, 4};
    rst = 1'b1;
    bus.i_stall = 1'b0;
    drive(4'h0, 0);
    repeat (3) step();
    chk("rst_wren", 32'(bus.o_wren), 32'd0);
    chk("rst_addr", bus.o_addr, 32'd0);
    chk("rst_wdat", bus.o_wdat, 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(4'hF, i);
      step();
    end
    drive(4'h0, 0);
    step();
    chk("idle_no_write", 32'(wr_cnt), 32'd0);
    chk("idle_no_done", 32'(o_done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      if (i == 0) begin
        chk("v0_1000", wr_mem[32'h1000], 32'h03020100);
        chk("v0_1004", wr_mem[32'h1004], 32'h07060504);
        chk("v0_1304", wr_mem[32'h1304], 32'h37363534);
      end
      if (i == 1) begin
        chk("v1_1004", wr_mem[32'h1004], 32'h00000504);
        chk("v1_1204", wr_mem[32'h1204], 32'h00002524);
      end
    end
    expect_wr = 1'b0;
    wr_cnt = 0;
    bus.i_stall = 1'b1;
    start(32'd24, 32'h1000, 32'h100);
    for (int i = 0; i < 24; i++) begin
      drive(4'b0001, i);
      step();
    end
    drive(4'h0, 0);
    chk("stall_overflow", 32'(o_overflow), 32'd1);
    chk("stall_no_write", 32'(wr_cnt), 32'd0);
    sb.push_back('{32'h1000, 32'h03020100});
    sb.push_back('{32'h1004, 32'h07060504});
    sb.push_back('{32'h1008, 32'h0B0A0908});
    sb.push_back('{32'h100C, 32'h0F0E0D0C});
    bus.i_stall = 1'b0;
    repeat (10) step();
    chk("stall_drain_count", 32'(wr_cnt), 32'd4);
    chk("stall_sb_empty", 32'(sb.size()), 32'd0);
    chk("overflow_held", 32'(o_overflow), 32'd1);
    start(32'd4, 32'h1000, 32'h100);
    chk("start_clears_overflow", 32'(o_overflow), 32'd0);
    wr_cnt = 0;
    model(32'd16, 32'h2000, 32'h100);
    start(32'd16, 32'h2000, 32'h100);
    n = 0;
    while (wr_cnt < 3 && n < 40) begin
      drive(4'hF, n);
      step();
      n++;
    end
    chk("mid_run_writes", 32'(wr_cnt >= 3), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wren", 32'(bus.o_wren), 32'd0);
    chk("mid_rst_addr", bus.o_addr, 32'd0);
    chk("mid_rst_wdat", bus.o_wdat, 32'd0);
    chk("mid_rst_done", 32'(o_done), 32'd0);
    chk("mid_rst_overflow", 32'(o_overflow), 32'd0);
    sb.delete();
    n = wr_cnt;
    drive(4'hF, 20);
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
    drive(4'h0, 0);
    chk("no_write_after_reset", 32'(wr_cnt), 32'(n));
    run_vec('{32'd4, 32'h2000, 32'h100, 4, 4});
    chk("rerun_2000", wr_mem[32'h2000], 32'h03020100);
    chk("rerun_2300", wr_mem[32'h2300], 32'h33323130);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
